// File: rtl/state_reader_pkg.sv
// Shared definitions for the SHA-256 working-variable store (read and write sides).
package state_reader_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NUM_VARS = 8;
  localparam int unsigned ADDR_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_NOP = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_A   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_B   = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_C   = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_D   = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_E   = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_F   = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_G   = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_H   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/state_reader.sv
// Snapshots working variables A..H on start and streams them out, address-tagged,
// over a valid/ready handshake; all outputs come straight from flops.
module state_reader
  import state_reader_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_A,
  input  logic [WIDTH-1:0]     in_B,
  input  logic [WIDTH-1:0]     in_C,
  input  logic [WIDTH-1:0]     in_D,
  input  logic [WIDTH-1:0]     in_E,
  input  logic [WIDTH-1:0]     in_F,
  input  logic [WIDTH-1:0]     in_G,
  input  logic [WIDTH-1:0]     in_H,
  input  logic                 start,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_word,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_next;
  logic [WIDTH-1:0]    r_snap      [NUM_VARS];
  logic [WIDTH-1:0]    w_snap_next [NUM_VARS];
  logic [WIDTH-1:0]    r_out_word;
  logic [WIDTH-1:0]    w_word_next;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [ADDR_W-1:0]   w_addr_next;
  logic                r_out_valid;
  logic                w_valid_next;
  logic                r_busy;
  logic                w_busy_next;
  logic                r_done;
  logic                w_done_next;
  logic                w_xfer;

  assign w_xfer = r_out_valid & out_ready;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_snap      <= '{default: '0};
      r_out_word  <= '0;
      r_out_addr  <= ADDR_NOP;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_snap      <= w_snap_next;
      r_out_word  <= w_word_next;
      r_out_addr  <= w_addr_next;
      r_out_valid <= w_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  // Next state and next output values; the next word is preselected so out_word is a flop
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_snap_next  = r_snap;
    w_word_next  = r_out_word;
    w_addr_next  = r_out_addr;
    w_valid_next = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_word_next = '0;
        w_addr_next = ADDR_NOP;
        if (start) begin
          w_snap_next  = '{in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H};
          w_idx_next   = ADDR_A;
          w_word_next  = in_A;
          w_addr_next  = ADDR_A;
          w_valid_next = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_valid_next = 1'b1;
        w_busy_next  = 1'b1;
        if (w_xfer) begin
          if (r_idx == ADDR_H) begin
            w_idx_next   = '0;
            w_word_next  = '0;
            w_addr_next  = ADDR_NOP;
            w_valid_next = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = DONE;
          end else begin
            // r_snap[idx] is entry (idx+1)-1, i.e. the word after the current one
            w_idx_next  = r_idx + 4'd1;
            w_word_next = r_snap[3'(r_idx)];
            w_addr_next = r_idx + 4'd1;
          end
        end
      end
      DONE: begin
        w_word_next  = '0;
        w_addr_next  = ADDR_NOP;
        w_state_next = IDLE;
      end
      default: begin
        w_idx_next   = '0;
        w_word_next  = '0;
        w_addr_next  = ADDR_NOP;
        w_state_next = IDLE;
      end
    endcase
  end

  assign out_word  = r_out_word;
  assign out_addr  = r_out_addr;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_state_reader.sv
// Directed bench for state_reader: reset, full stream, backpressure, snapshot
// isolation, start while busy, async reset mid-stream and back-to-back streams.
module tb_state_reader;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H;
  logic        start;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_addr;
  logic        out_valid;
  logic        busy;
  logic        done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] ref_v [8];

  state_reader #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_A     (in_A),
    .in_B     (in_B),
    .in_C     (in_C),
    .in_D     (in_D),
    .in_E     (in_E),
    .in_F     (in_F),
    .in_G     (in_G),
    .in_H     (in_H),
    .start    (start),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(out_valid), 32'd0);
    check({tag, " busy"},  32'(busy),      32'd0);
    check({tag, " done"},  32'(done),      32'd0);
    check({tag, " addr"},  32'(out_addr),  32'd0);
    check({tag, " word"},  out_word,       32'd0);
  endtask

  task automatic load_ref();
    in_A = ref_v[0]; in_B = ref_v[1]; in_C = ref_v[2]; in_D = ref_v[3];
    in_E = ref_v[4]; in_F = ref_v[5]; in_G = ref_v[6]; in_H = ref_v[7];
  endtask

  // Called in the first cycle after start was sampled; checks A..H, done, then idle
  task automatic expect_stream(input string tag, input int stall_k, input int nstall,
                               input int start_k, input bit start_done);
    for (int k = 0; k < 8; k++) begin
      start = (k == start_k);
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int s = 0; s < nstall; s++) begin
          check($sformatf("%s stall%0d word", tag, s), out_word, ref_v[k]);
          check($sformatf("%s stall%0d addr", tag, s), 32'(out_addr), 32'(k + 1));
          check($sformatf("%s stall%0d valid", tag, s), 32'(out_valid), 32'd1);
          tick();
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s w%0d word", tag, k), out_word, ref_v[k]);
      check($sformatf("%s w%0d addr", tag, k), 32'(out_addr), 32'(k + 1));
      check($sformatf("%s w%0d valid", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s w%0d busy", tag, k), 32'(busy), 32'd1);
      check($sformatf("%s w%0d done", tag, k), 32'(done), 32'd0);
      tick();
    end
    start = start_done;
    check({tag, " done pulse"}, 32'(done),      32'd1);
    check({tag, " done valid"}, 32'(out_valid), 32'd0);
    check({tag, " done busy"},  32'(busy),      32'd1);
    tick();
    start = 1'b0;
    check_idle({tag, " after"});
  endtask

  initial begin
    ref_v[0] = 32'h6a09e667; ref_v[1] = 32'hbb67ae85;
    ref_v[2] = 32'h3c6ef372; ref_v[3] = 32'ha54ff53a;
    ref_v[4] = 32'h510e527f; ref_v[5] = 32'h9b05688c;
    ref_v[6] = 32'h1f83d9ab; ref_v[7] = 32'h5be0cd19;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    load_ref();
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post-reset");

    // Full stream with ready held high
    start = 1'b1;
    tick();
    expect_stream("basic", -1, 0, -1, 1'b0);

    // Three-cycle stall on word C
    start = 1'b1;
    tick();
    expect_stream("bp", 2, 3, -1, 1'b0);

    // Inputs overwritten one cycle after start must not reach the stream
    start = 1'b1;
    tick();
    in_A = '1; in_B = '1; in_C = '1; in_D = '1;
    in_E = '1; in_F = '1; in_G = '1; in_H = '1;
    expect_stream("iso", -1, 0, -1, 1'b0);
    load_ref();

    // Start pulses during word E and during DONE are ignored
    start = 1'b1;
    tick();
    expect_stream("busy-start", -1, 0, 4, 1'b1);
    tick();
    check_idle("busy-start no restart");

    // Asynchronous reset between edges while word F is presented
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("pre-rst addr", 32'(out_addr), 32'd6);
    check("pre-rst word", out_word, ref_v[5]);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async rst");
    @(negedge clk);
    check_idle("async rst held");
    rst_n = 1'b1;
    tick();
    check_idle("async rst released");
    start = 1'b1;
    tick();
    expect_stream("post-rst", -1, 0, -1, 1'b0);

    // Back-to-back: start and ready held high, a stream every 10 cycles
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int c = 0; c < 30; c++) begin
      if ((c % 10) < 8) begin
        check($sformatf("b2b c%0d word", c), out_word, ref_v[c % 10]);
        check($sformatf("b2b c%0d addr", c), 32'(out_addr), 32'((c % 10) + 1));
        check($sformatf("b2b c%0d valid", c), 32'(out_valid), 32'd1);
        check($sformatf("b2b c%0d done", c), 32'(done), 32'd0);
      end else if ((c % 10) == 8) begin
        check($sformatf("b2b c%0d done", c), 32'(done), 32'd1);
        check($sformatf("b2b c%0d valid", c), 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("b2b c%0d idle valid", c), 32'(out_valid), 32'd0);
        check($sformatf("b2b c%0d idle busy", c), 32'(busy), 32'd0);
      end
      tick();
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
